// File: rtl/std_div_seq.sv
// Unsigned restoring divider that produces one quotient bit per cycle, with width+1 cycles from start to result.
// A start is accepted only in IDLE or DONE; starts seen while BUSY are dropped. `STD_DIV_SEQ_ZERO_CHK_EN` enables the zero-divisor early exit.
module std_div_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] left,
    input  logic             left_read_in,
    input  logic [width-1:0] right,
    input  logic             right_read_in,
    input  logic             valid,
    output logic             ready,
    output logic [width-1:0] out,
    output logic [width-1:0] out_remainder,
    output logic             out_read_out,
    output logic             div_zero
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width-1:0] dsr_q, dsr_d;
    logic [width-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] quo_q, quo_d;
    logic [width-1:0] rmo_q, rmo_d;
    logic             rdy_q, rdy_d;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
    logic             dz_q, dz_d;
`endif

    logic             start;
    logic [width:0]   shifted;
    logic [width:0]   trial;
    logic             borrow;
    logic [width-1:0] step_rem;
    logic [width-1:0] step_quo;

    assign start = valid & left_read_in & right_read_in;

    // rem_q stays below 2^(steps taken), so its MSB is always zero when shifted.
    assign shifted  = {rem_q, dvd_q[width-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign borrow   = trial[width];
    assign step_rem = borrow ? shifted[width-1:0] : trial[width-1:0];
    assign step_quo = {dvd_q[width-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        rdy_d   = 1'b0;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    dvd_d   = left;
                    dsr_d   = right;
                    rem_d   = '0;
                    cnt_d   = CW'(width);
                    state_d = S_BUSY;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
                    if (right == '0) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        quo_d   = '1;
                        rmo_d   = left;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            S_BUSY: begin
                dvd_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                    quo_d   = step_quo;
                    rmo_d   = step_rem;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            rdy_q   <= 1'b0;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            rdy_q   <= rdy_d;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign ready         = rdy_q;
    assign out_read_out  = rdy_q;
    assign out           = quo_q;
    assign out_remainder = rmo_q;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
    assign div_zero      = dz_q;
`else
    assign div_zero      = 1'b0;
`endif

endmodule

// File: tb/tb_std_div_seq.sv
// Scoreboard bench for std_div_seq at width 8 and width 32, with a plain-arithmetic reference model.
module tb_std_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] left_v = '0;
    logic [31:0] right_v = '0;
    logic        lrd = 1'b0;
    logic        rrd = 1'b0;
    logic        v8 = 1'b0;
    logic        v32 = 1'b0;

    logic        rdy8, ordy8, dz8;
    logic [7:0]  out8, rem8;
    logic        rdy32, ordy32, dz32;
    logic [31:0] out32, rem32;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb32[$];
    exp_t hold[2];

    std_div_seq #(.width(8)) u_div8 (
        .clk(clk), .reset(reset),
        .left(left_v[7:0]), .left_read_in(lrd),
        .right(right_v[7:0]), .right_read_in(rrd),
        .valid(v8), .ready(rdy8), .out(out8), .out_remainder(rem8),
        .out_read_out(ordy8), .div_zero(dz8)
    );

    std_div_seq #(.width(32)) u_div32 (
        .clk(clk), .reset(reset),
        .left(left_v), .left_read_in(lrd),
        .right(right_v), .right_read_in(rrd),
        .valid(v32), .ready(rdy32), .out(out32), .out_remainder(rem32),
        .out_read_out(ordy32), .div_zero(dz32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_one(input bit s, input logic rdy, input logic ordy,
                             input logic [31:0] o, input logic [31:0] r, input logic dz);
        exp_t e;
        bit   have;
        have = s ? (sb32.size() > 0) : (sb8.size() > 0);
        if (have) e = s ? sb32[0] : sb8[0];
        cmp(s ? "ready_eq_read_out32" : "ready_eq_read_out8", 32'(ordy), 32'(rdy));
        if (have && e.cyc < cyc) begin
            cmp(s ? "missing_ready32" : "missing_ready8", 32'(cyc), 32'(e.cyc));
            if (s) void'(sb32.pop_front()); else void'(sb8.pop_front());
            have = s ? (sb32.size() > 0) : (sb8.size() > 0);
            if (have) e = s ? sb32[0] : sb8[0];
        end
        if (rdy === 1'b1) begin
            if (!have) begin
                cmp(s ? "spurious_ready32" : "spurious_ready8", 32'(rdy), 32'd0);
            end else begin
                if (s) void'(sb32.pop_front()); else void'(sb8.pop_front());
                cmp(s ? "latency32" : "latency8", 32'(cyc), 32'(e.cyc));
                cmp(s ? "quotient32" : "quotient8", o, e.q);
                cmp(s ? "remainder32" : "remainder8", r, e.r);
                cmp(s ? "div_zero32" : "div_zero8", 32'(dz), 32'(e.dz));
                hold[s] = e;
            end
        end else begin
            cmp(s ? "hold_out32" : "hold_out8", o, hold[s].q);
            cmp(s ? "hold_rem32" : "hold_rem8", r, hold[s].r);
            cmp(s ? "hold_dz32" : "hold_dz8", 32'(dz), 32'(hold[s].dz));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_one(1'b0, rdy8, ordy8, {24'd0, out8}, {24'd0, rem8}, dz8);
            check_one(1'b1, rdy32, ordy32, out32, rem32, dz32);
        end
    end

    // Drive non-starting traffic: valid may be high but never with both read flags.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            left_v  = $urandom;
            right_v = $urandom;
            lrd     = 1'($urandom);
            rrd     = lrd ? 1'b0 : 1'($urandom);
            v8      = 1'($urandom);
            v32     = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Full start requests aimed at a DUT that is known to be BUSY.
    task automatic noise(input bit s, input int n);
        for (int i = 0; i < n; i++) begin
            left_v  = $urandom;
            right_v = $urandom;
            lrd     = 1'b1;
            rrd     = 1'b1;
            v8      = s ? 1'b0 : 1'($urandom);
            v32     = s ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        v8 = 1'b0; v32 = 1'b0;
    endtask

    task automatic issue(input bit s, input logic [31:0] a_in, input logic [31:0] b_in, output int lat);
        logic [31:0] mask, a, b;
        exp_t        e;
        int          w;
        w    = s ? 32 : 8;
        mask = s ? 32'hFFFF_FFFF : 32'h0000_00FF;
        a    = a_in & mask;
        b    = b_in & mask;
        e.q  = (b == 0) ? mask : a / b;
        e.r  = (b == 0) ? a : a % b;
        lat  = w + 1;
        e.dz = 1'b0;
`ifdef STD_DIV_SEQ_ZERO_CHK_EN
        if (b == 0) begin
            lat  = 1;
            e.dz = 1'b1;
        end
`endif
        e.cyc   = cyc + lat;
        left_v  = a;
        right_v = b;
        lrd     = 1'b1;
        rrd     = 1'b1;
        v8      = ~s;
        v32     = s;
        if (s) sb32.push_back(e); else sb8.push_back(e);
        @(posedge clk); #1;
        v8 = 1'b0; v32 = 1'b0; lrd = 1'b0; rrd = 1'b0;
        left_v = $urandom; right_v = $urandom;
    endtask

    task automatic random_ops(input bit s, input int n);
        int          lat, gap;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (s && $urandom_range(0, 1) == 0) b = b >> $urandom_range(8, 28);
            issue(s, a, b, lat);
            gap = $urandom_range(0, 2);
            if (lat > 2 && $urandom_range(0, 2) == 0) begin
                noise(s, lat - 2);
                idle(1 + gap);
            end else begin
                idle(lat - 1 + gap);
            end
        end
        idle(40);
    endtask

    initial begin
        int lat;
        hold[0] = '{q: 0, r: 0, dz: 0, cyc: 0};
        hold[1] = '{q: 0, r: 0, dz: 0, cyc: 0};
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // valid with the divisor flag low must never start an operation
        left_v = 32'd100; right_v = 32'd7; lrd = 1'b1; rrd = 1'b0; v8 = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        v8 = 1'b0; lrd = 1'b0;

        issue(1'b0, 32'd100, 32'd7, lat);
        idle(lat + 4);

        issue(1'b0, 32'd255, 32'd1, lat);
        idle(lat - 1);
        issue(1'b0, 32'd200, 32'd255, lat);
        idle(lat + 2);

        issue(1'b0, 32'd37, 32'd0, lat);
        idle(lat + 3);

        // reset lands mid-operation; the pending result must never appear
        issue(1'b0, 32'd50, 32'd3, lat);
        idle(3);
        reset = 1'b1;
        @(posedge clk); #1;
        sb8.delete();
        sb32.delete();
        hold[0] = '{q: 0, r: 0, dz: 0, cyc: 0};
        hold[1] = '{q: 0, r: 0, dz: 0, cyc: 0};
        reset = 1'b0;
        idle(12);

        random_ops(1'b0, 150);

        issue(1'b1, 32'hFFFF_FFFF, 32'h0001_0000, lat);
        idle(lat + 2);
        issue(1'b1, 32'h1234_5678, 32'd0, lat);
        idle(lat + 2);
        random_ops(1'b1, 25);

        cmp("pending8", 32'(sb8.size()), 32'd0);
        cmp("pending32", 32'(sb32.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
